// File: rtl/mul_1279_shift_add.sv
// Sequential shift-add multiplier: one partial product per clock, 21-bit exact product
// of two 11-bit residues mod 1279, with valid/ready on both sides and an operand range flag.
module mul_1279_shift_add #(
    parameter int Q = 1279,
    parameter int W = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-2:0]   prod,
    output logic             out_err
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // the producer holds its payload stable until that edge, ready never depends on valid.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [W:0] Q_L     = (W+1)'(Q);
    localparam logic [3:0] CNT_END = 4'(W-1);

    state_t           state_q, state_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [W-1:0]     mcand_q, mcand_d;
    logic [W-1:0]     mplier_q, mplier_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             err_q, err_d;

    logic             accept;
    logic [2*W-1:0]   mcand_ext;

    assign mcand_ext = {{W{1'b0}}, mcand_q};

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
        accept   = in_valid && in_ready;

        case (state_q)
            RUN: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + (mcand_ext << cnt_q);
                end
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 4'd1;
                if (cnt_q == CNT_END) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready && !accept) begin
                    state_d = IDLE;
                end
            end
            default: begin
            end
        endcase

        // A new pair may load from IDLE or overlap the consuming edge of DONE.
        if (accept) begin
            state_d  = RUN;
            acc_d    = '0;
            mcand_d  = a;
            mplier_d = b;
            cnt_d    = '0;
            err_d    = ({1'b0, a} >= Q_L) || ({1'b0, b} >= Q_L);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    // The top accumulator bit is dropped; in-range operands never reach it.
    assign out_valid = (state_q == DONE);
    assign prod      = acc_q[2*W-2:0];
    assign out_err   = err_q;

endmodule

// File: tb/tb_mul_1279_shift_add.sv
// Self-checking bench for mul_1279_shift_add: scoreboard of expected {err, prod} per accepted
// pair, plus scenario tasks for reset, latency, range flag, backpressure, streaming and abort.
module tb_mul_1279_shift_add;

    localparam int Q  = 1279;
    localparam int W  = 11;
    localparam int PW = 2*W-1;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] prod;
    logic          out_err;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [PW:0]   exp_q[$];
    int            out_cyc_q[$];
    logic [PW-1:0] last_prod;

    mul_1279_shift_add #(.Q(Q), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .prod      (prod),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [PW:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb);
        logic [2*W-1:0] p;
        logic           e;
        p = (2*W)'(ma) * (2*W)'(mb);
        e = (int'(ma) >= Q) || (int'(mb) >= Q);
        return {e, p[PW-1:0]};
    endfunction

    // Scoreboard: pop on output transfer, push on input transfer (both seen before the edge).
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_result: got err=%0b prod=%0d, none expected", out_err, prod);
            end else begin
                logic [PW:0] e;
                e = exp_q.pop_front();
                if ({out_err, prod} !== e) begin
                    n_fail++;
                    $display("FAIL result: got err=%0b prod=%0d, expected err=%0b prod=%0d",
                             out_err, prod, e[PW], e[PW-1:0]);
                end
            end
            last_prod = prod;
            out_cyc_q.push_back(cyc);
        end
        if (rst_n && in_valid && in_ready) begin
            exp_q.push_back(model(a, b));
        end
    end

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input bit keep);
        bit ok;
        a = ta;
        b = tb_v;
        in_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready=%0b, expected 1 within 200 cycles", in_ready);
        end
        @(posedge clk);
        #1;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        #3;
        n_cmp++;
        if ({in_ready, out_valid, out_err, prod} !== {1'b1, 1'b0, 1'b0, {PW{1'b0}}}) begin
            n_fail++;
            $display("FAIL reset_outputs: got in_ready=%0b out_valid=%0b out_err=%0b prod=%0d, expected 1 0 0 0",
                     in_ready, out_valid, out_err, prod);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_latency();
        int n;
        out_ready = 1'b1;
        send(11'd1278, 11'd1278, 0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n++;
            if (out_valid) break;
        end
        n_cmp++;
        if (n !== 12) begin
            n_fail++;
            $display("FAIL latency: out_valid seen %0d cycles after accept, expected 12", n);
        end
        drain();
        n_cmp++;
        if ((int'(last_prod) % Q) !== 1) begin
            n_fail++;
            $display("FAIL reduced_1278sq: got %0d, expected 1", int'(last_prod) % Q);
        end
    endtask

    task automatic test_values();
        out_ready = 1'b1;
        send(11'd1000, 11'd1000, 0);
        send(11'd0, 11'd777, 0);
        send(11'd1, 11'd1, 0);
        send(11'd1278, 11'd0, 0);
        for (int i = 0; i < 4; i++) begin
            send(11'($urandom_range(0, Q-1)), 11'($urandom_range(0, Q-1)), 0);
        end
        drain();
    endtask

    task automatic test_range();
        out_ready = 1'b1;
        send(11'd1279, 11'd5, 0);
        send(11'd5, 11'd5, 0);
        send(11'd2047, 11'd2047, 0);
        send(11'd3, 11'd1279, 0);
        send(11'd1278, 11'd1278, 0);
        drain();
    endtask

    task automatic test_backpressure();
        bit ok;
        out_ready = 1'b0;
        send(11'd1000, 11'd3, 0);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL stall_valid: out_valid=%0b, expected 1 within 40 cycles", out_valid);
        end
        @(posedge clk);
        #1;
        a = 11'd7;
        b = 11'd9;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({out_valid, in_ready, prod} !== {1'b1, 1'b0, PW'(3000)}) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got out_valid=%0b in_ready=%0b prod=%0d, expected 1 0 3000",
                         i, out_valid, in_ready, prod);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b11) begin
            n_fail++;
            $display("FAIL release: got out_valid=%0b in_ready=%0b, expected 1 1", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL overlap_accept: got out_valid=%0b in_ready=%0b, expected 0 0", out_valid, in_ready);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        out_cyc_q.delete();
        for (int i = 0; i < 4; i++) begin
            send(11'($urandom_range(0, Q-1)), 11'($urandom_range(0, Q-1)), 1);
        end
        in_valid = 1'b0;
        drain();
        n_cmp++;
        if (out_cyc_q.size() !== 4) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d results, expected 4", out_cyc_q.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                n_cmp++;
                if (out_cyc_q[i] - out_cyc_q[i-1] !== 12) begin
                    n_fail++;
                    $display("FAIL b2b_spacing[%0d]: got %0d cycles, expected 12",
                             i, out_cyc_q[i] - out_cyc_q[i-1]);
                end
            end
        end
    endtask

    task automatic test_abort();
        out_ready = 1'b1;
        send(11'd1234, 11'd1111, 0);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, in_ready, prod} !== {1'b0, 1'b1, {PW{1'b0}}}) begin
            n_fail++;
            $display("FAIL abort_outputs: got out_valid=%0b in_ready=%0b prod=%0d, expected 0 1 0",
                     out_valid, in_ready, prod);
        end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send(11'd11, 11'd13, 0);
        drain();
        n_cmp++;
        if (last_prod !== PW'(143)) begin
            n_fail++;
            $display("FAIL abort_next: got prod=%0d, expected 143", last_prod);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_values();
        test_range();
        test_backpressure();
        test_back_to_back();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
